// File: rtl/display_scan_driver_if.sv
// Value-load channel into the display scan driver.
// Handshake: the source holds value stable while value_valid is high; a word
// transfers on every rising clk edge where value_valid & value_ready are both
// high; value_ready does not depend on value_valid in the same cycle.
interface display_scan_driver_if;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;

  modport master (output value, output value_valid, input value_ready);
  modport slave  (input value, input value_valid, output value_ready);
endinterface

// File: rtl/display_scan_driver.sv
// Refresh prescaler, digit select and double-buffered hex-to-seven-segment
// decoder for a 4-digit multiplexed display. New words commit only when the
// scan wraps from the last digit to the first, so one frame never mixes two
// words.
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        blank_lz,
  display_scan_driver_if.slave        bus,
  output logic [6:0]                  seg0,
  output logic [6:0]                  seg1,
  output logic [6:0]                  seg2,
  output logic [6:0]                  seg3,
  output logic [1:0]                  sel,
  output logic                        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic [15:0]      pending_q;
  logic             pend_full_q;
  logic [15:0]      active_q;
  logic [6:0]       seg0_q, seg1_q, seg2_q, seg3_q;
  logic             frame_tick_q;

  logic             digit_tick;
  logic             boundary;
  logic             transfer;
  logic [6:0]       seg0_d, seg1_d, seg2_d, seg3_d;

  // Active-low hex table, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign digit_tick = enable & (cnt_q == CNT_LAST);
  assign boundary   = digit_tick & (sel_q == 2'b11);
  // Ready comes straight from the buffer-full flop, never from value_valid.
  assign transfer   = bus.value_valid & ~pend_full_q;

  // Next segment pattern: decode each nibble, blanking leading zeros when asked.
  // The rightmost digit is always shown so a zero word still reads "0".
  always_comb begin
    seg0_d = hex7(active_q[15:12]);
    seg1_d = hex7(active_q[11:8]);
    seg2_d = hex7(active_q[7:4]);
    seg3_d = hex7(active_q[3:0]);
    if (blank_lz && active_q[15:12] == 4'h0) begin
      seg0_d = 7'h7F;
      if (active_q[11:8] == 4'h0) begin
        seg1_d = 7'h7F;
        if (active_q[7:4] == 4'h0) seg2_d = 7'h7F;
      end
    end
  end

  // Prescaler, digit select, double buffer and registered segment outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= 2'b00;
      pending_q    <= 16'h0000;
      pend_full_q  <= 1'b0;
      active_q     <= 16'h0000;
      seg0_q       <= 7'h40;
      seg1_q       <= 7'h40;
      seg2_q       <= 7'h40;
      seg3_q       <= 7'h40;
      frame_tick_q <= 1'b0;
    end else begin
      if (enable) cnt_q <= digit_tick ? '0 : cnt_q + 1'b1;
      if (digit_tick) sel_q <= sel_q + 2'b01;
      frame_tick_q <= boundary;
      // A commit needs a full buffer and a transfer needs an empty one, so the
      // two never touch pending_q/pend_full_q in the same cycle; a word taken
      // on a boundary cycle therefore waits for the following boundary.
      if (boundary && pend_full_q) begin
        active_q    <= pending_q;
        pend_full_q <= 1'b0;
      end
      if (transfer) begin
        pending_q   <= bus.value;
        pend_full_q <= 1'b1;
      end
      seg0_q <= seg0_d;
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
      seg3_q <= seg3_d;
    end
  end

  assign bus.value_ready = ~pend_full_q;
  assign seg0            = seg0_q;
  assign seg1            = seg1_q;
  assign seg2            = seg2_q;
  assign seg3            = seg3_q;
  assign sel             = sel_q;
  assign frame_tick      = frame_tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with REFRESH_DIV = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point too.
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       blank_lz;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [1:0] sel;
  logic       frame_tick;

  int vectors     = 0;
  int miscompares = 0;

  logic [27:0] exp_q[$];

  display_scan_driver_if bus ();

  display_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .bus        (bus),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .sel        (sel),
    .frame_tick (frame_tick)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  // Driver / checking tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] segs();
    return {seg0, seg1, seg2, seg3};
  endfunction

  task automatic wait_sel(input logic [1:0] t);
    int k = 0;
    while (sel !== t && k < 64) begin
      step();
      k++;
    end
    check("wait_sel", 32'(sel), 32'(t));
  endtask

  task automatic wait_frame();
    int k = 0;
    while (frame_tick !== 1'b1 && k < 64) begin
      step();
      k++;
    end
    check("wait_frame", 32'(frame_tick), 32'd1);
  endtask

  // Count samples for which sel keeps its current value.
  task automatic measure_hold(output int n);
    logic [1:0] cur;
    cur = sel;
    n = 0;
    while (sel === cur && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic offer(input logic [15:0] v);
    bus.value       = v;
    bus.value_valid = 1'b1;
    step();
    bus.value_valid = 1'b0;
    check("offer_ready_fall", 32'(bus.value_ready), 32'd0);
  endtask

  // Stimulus
  initial begin
    int n;
    int k;
    logic stalled_ok;

    rst_n = 1'b0; enable = 1'b1; blank_lz = 1'b0;
    bus.value = 16'h0000; bus.value_valid = 1'b0;

    // Reset
    repeat (3) step();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_segs", 32'(segs()), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    check("rst_ready", 32'(bus.value_ready), 32'd1);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_release_tick", 32'(frame_tick), 32'd0);

    // Free scan: each sel value held 4 cycles, wrap pulses frame_tick
    wait_sel(2'd1);
    measure_hold(n); check("hold_sel1", 32'(n), 32'd4); check("sel_after1", 32'(sel), 32'd2);
    measure_hold(n); check("hold_sel2", 32'(n), 32'd4); check("sel_after2", 32'(sel), 32'd3);
    measure_hold(n); check("hold_sel3", 32'(n), 32'd4); check("sel_wrap", 32'(sel), 32'd0);
    check("wrap_tick", 32'(frame_tick), 32'd1);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 64);
    check("frame_period", 32'(n), 32'd16);

    // Load 12AF
    offer(16'h12AF);
    wait_frame();
    check("load_ready_rise", 32'(bus.value_ready), 32'd1);
    step();
    check("load_segs", 32'(segs()), 32'({7'h79, 7'h24, 7'h08, 7'h0E}));
    check("load_ready", 32'(bus.value_ready), 32'd1);

    // Backpressure: 1111 then 2222 held valid
    exp_q.push_back({7'h79, 7'h79, 7'h79, 7'h79});
    exp_q.push_back({7'h79, 7'h79, 7'h79, 7'h79});
    exp_q.push_back({7'h24, 7'h24, 7'h24, 7'h24});
    bus.value = 16'h1111; bus.value_valid = 1'b1;
    step();
    check("bp_ready_fall", 32'(bus.value_ready), 32'd0);
    bus.value = 16'h2222;
    stalled_ok = 1'b1;
    k = 0;
    while (frame_tick !== 1'b1 && k < 64) begin
      if (bus.value_ready !== 1'b0) stalled_ok = 1'b0;
      step();
      k++;
    end
    check("bp_ready_stays_low", 32'(stalled_ok), 32'd1);
    check("bp_boundary", 32'(frame_tick), 32'd1);
    check("bp_ready_rise", 32'(bus.value_ready), 32'd1);
    step();
    bus.value_valid = 1'b0;
    check("bp_second_taken", 32'(bus.value_ready), 32'd0);
    check("bp_first_shown", 32'(segs()), 32'(exp_q.pop_front()));
    wait_frame();
    check("bp_first_full_frame", 32'(segs()), 32'(exp_q.pop_front()));
    step();
    check("bp_second_shown", 32'(segs()), 32'(exp_q.pop_front()));

    // Leading-zero blanking
    blank_lz = 1'b1;
    offer(16'h0050);
    wait_frame();
    step();
    check("lz_0050", 32'(segs()), 32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
    offer(16'h0000);
    wait_frame();
    step();
    check("lz_0000", 32'(segs()), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    blank_lz = 1'b0;
    step();
    check("lz_off", 32'(segs()), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

    // Freeze mid-slot at sel=10
    wait_sel(2'd2);
    step();
    enable = 1'b0;
    repeat (10) step();
    check("freeze_sel", 32'(sel), 32'd2);
    check("freeze_tick", 32'(frame_tick), 32'd0);
    enable = 1'b1;
    n = 0;
    step();
    while (sel === 2'd2 && n < 64) begin
      n++;
      step();
    end
    check("resume_remaining", 32'(n), 32'd2);
    check("resume_sel", 32'(sel), 32'd3);

    // Reset with a pending word: 8888 must never appear
    wait_frame();
    offer(16'h8888);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst2_sel", 32'(sel), 32'd0);
    check("rst2_ready", 32'(bus.value_ready), 32'd1);
    check("rst2_tick", 32'(frame_tick), 32'd0);
    check("rst2_segs", 32'(segs()), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    wait_frame();
    step();
    check("rst2_discarded", 32'(segs()), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    check("rst2_ready_after", 32'(bus.value_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
